csr_lock_table: RTL and testbench



---
 rtl/config_pkg.sv | 27 ++
 rtl/csr_lock_table_if.sv | 33 +++
 rtl/csr_lock_entry.sv | 48 ++++
 rtl/csr_lock_table.sv | 113 +++++++++++
 tb/tb_csr_lock_table.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// Shared CSR lock-table types.
// The command word overlays csr_wdata[15:0].
package config_pkg;

  localparam int CmdAddrW = 12;

  typedef enum logic [1:0] {
    MODE_NONE    = 2'b00,
    MODE_WR      = 2'b01,
    MODE_ACC     = 2'b10,
    MODE_ACC_ALT = 2'b11
  } csr_lock_mode_t;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_REMOVE = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_LOCK   = 2'b11
  } csr_lock_op_t;

  typedef struct packed {
    csr_lock_op_t          op;
    csr_lock_mode_t        mode;
    logic [CmdAddrW-1:0]   addr;
  } csr_lock_cmd_t;

endpackage

// File: rtl/csr_lock_table_if.sv
// CSR access bus seen by the lock table,
// plus its status outputs.
interface csr_lock_table_if #(
  parameter int Entries   = 8,
  parameter int AddrWidth = 12
);
  localparam int CntW = $clog2(Entries) + 1;

  logic                 csr_enable;
  logic [AddrWidth-1:0] csr_addr;
  logic                 csr_is_write;
  logic [31:0]          csr_wdata;
  logic                 csr_enable_out;
  logic                 violation;
  logic [AddrWidth-1:0] violation_addr;
  logic [CntW-1:0]      count;
  logic                 full;
  logic                 locked;
  logic                 cmd_err;

  modport master (
    output csr_enable, csr_addr, csr_is_write, csr_wdata,
    input  csr_enable_out, violation, violation_addr,
    input  count, full, locked, cmd_err
  );

  modport slave (
    input  csr_enable, csr_addr, csr_is_write, csr_wdata,
    output csr_enable_out, violation, violation_addr,
    output count, full, locked, cmd_err
  );

endinterface

// File: rtl/csr_lock_entry.sv
// One lock entry: valid/addr/mode registers,
// target match for commands and access block.
module csr_lock_entry
  import config_pkg::*;
#(
  parameter int AddrWidth = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_i,
  input  logic                 clr_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  csr_lock_mode_t       mode_i,
  input  logic [AddrWidth-1:0] look_addr_i,
  input  logic                 look_wr_i,
  output logic                 valid_o,
  output logic                 tgt_hit_o,
  output logic                 block_o
);

  logic                 valid_q;
  logic [AddrWidth-1:0] addr_q;
  csr_lock_mode_t       mode_q;
  logic                 hit;
  logic                 acc_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      mode_q  <= MODE_NONE;
    end else if (set_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      mode_q  <= mode_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign hit       = valid_q && (addr_q == look_addr_i);
  assign acc_mode  = (mode_q == MODE_ACC) ||
                     (mode_q == MODE_ACC_ALT);
  assign block_o   = hit && (acc_mode || look_wr_i);
  assign tgt_hit_o = valid_q && (addr_q == addr_i);
  assign valid_o   = valid_q;

endmodule

// File: rtl/csr_lock_table.sv
// CSR access-lock table: gates csr_enable and
// executes ADD/REMOVE/CLEAR/LOCK commands.
module csr_lock_table
  import config_pkg::*;
#(
  parameter int                   Entries   = 8,
  parameter int                   AddrWidth = 12,
  parameter logic [AddrWidth-1:0] CmdAddr   = 'h4FF
) (
  input logic             clk,
  input logic             reset,
  csr_lock_table_if.slave bus
);

  localparam int CntW = $clog2(Entries) + 1;

  csr_lock_cmd_t        cmd;
  logic [AddrWidth-1:0] tgt;
  logic [Entries-1:0]   valid, tgt_hit, block;
  logic [Entries-1:0]   set, clr, ff;
  logic                 ff_any, present;
  logic                 cmd_wr, cmd_go, blocked;
  logic                 is_add, is_rem, is_clr, is_lock;
  logic                 add_bad, add_ok, add_err;
  logic [CntW-1:0]      count_q, count_d;
  logic                 locked_q, cmd_err_q, viol_q;
  logic [AddrWidth-1:0] viol_addr_q;
  logic                 unused_wdata;

  assign cmd          = csr_lock_cmd_t'(bus.csr_wdata[15:0]);
  assign unused_wdata = ^bus.csr_wdata[31:16];
  assign tgt          = AddrWidth'(cmd.addr);

  assign cmd_wr  = bus.csr_enable && bus.csr_is_write &&
                   (bus.csr_addr == CmdAddr);
  assign cmd_go  = cmd_wr && !locked_q;
  // Once frozen, command writes are themselves blocked.
  assign blocked = (|block) || (cmd_wr && locked_q);

  assign is_add  = cmd_go && (cmd.op == OP_ADD);
  assign is_rem  = cmd_go && (cmd.op == OP_REMOVE);
  assign is_clr  = cmd_go && (cmd.op == OP_CLEAR);
  assign is_lock = cmd_go && (cmd.op == OP_LOCK);

  assign present = |tgt_hit;
  assign add_bad = (cmd.mode == MODE_NONE) || (tgt == CmdAddr);
  assign add_ok  = is_add && !add_bad && (present || ff_any);
  assign add_err = is_add && !add_ok;

  always_comb begin
    ff = '0;
    for (int i = Entries - 1; i >= 0; i--) begin
      if (!valid[i]) ff = Entries'(1) << i;
    end
  end
  assign ff_any = |ff;

  assign set = add_ok ? (present ? tgt_hit : ff) : '0;
  assign clr = is_clr ? '1 : (is_rem ? tgt_hit : '0);

  for (genvar i = 0; i < Entries; i++) begin : g_ent
    csr_lock_entry #(
      .AddrWidth(AddrWidth)
    ) u_ent (
      .clk        (clk),
      .reset      (reset),
      .set_i      (set[i]),
      .clr_i      (clr[i]),
      .addr_i     (tgt),
      .mode_i     (cmd.mode),
      .look_addr_i(bus.csr_addr),
      .look_wr_i  (bus.csr_is_write),
      .valid_o    (valid[i]),
      .tgt_hit_o  (tgt_hit[i]),
      .block_o    (block[i])
    );
  end

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      is_clr:               count_d = '0;
      is_rem && present:    count_d = count_q - CntW'(1);
      add_ok && !present:   count_d = count_q + CntW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      locked_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      viol_q      <= 1'b0;
      viol_addr_q <= '0;
    end else begin
      count_q <= count_d;
      viol_q  <= bus.csr_enable && blocked;
      if (is_lock) locked_q <= 1'b1;
      if (add_err) cmd_err_q <= 1'b1;
      if (bus.csr_enable && blocked) viol_addr_q <= bus.csr_addr;
    end
  end

  assign bus.csr_enable_out = bus.csr_enable && !blocked;
  assign bus.violation      = viol_q;
  assign bus.violation_addr = viol_addr_q;
  assign bus.count          = count_q;
  assign bus.full           = (count_q == CntW'(Entries));
  assign bus.locked         = locked_q;
  assign bus.cmd_err        = cmd_err_q;

endmodule

// File: tb/tb_csr_lock_table.sv
// Scoreboard bench for csr_lock_table: gating is checked
// live, violations are queued and checked a cycle later.
module tb_csr_lock_table;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_lock_table_if #(.Entries(8), .AddrWidth(12)) ifc ();

  csr_lock_table #(
    .Entries  (8),
    .AddrWidth(12),
    .CmdAddr  (12'h4FF)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (ifc.slave)
  );

  typedef struct {
    logic        viol;
    logic [11:0] va;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] model_va = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("violation", ifc.violation, e.viol);
      chk("viol_addr", ifc.violation_addr, e.va);
    end
  endtask

  task automatic acc(input logic en, input logic [11:0] a,
                     input logic w, input logic [31:0] d,
                     input logic exp_en);
    exp_t e;
    @(negedge clk);
    drain();
    ifc.csr_enable   = en;
    ifc.csr_addr     = a;
    ifc.csr_is_write = w;
    ifc.csr_wdata    = d;
    #1 chk("en_out", ifc.csr_enable_out, exp_en);
    e.viol = en && !exp_en;
    if (e.viol) model_va = a;
    e.va = model_va;
    sb.push_back(e);
  endtask

  task automatic idle();
    acc(1'b0, 12'h000, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic cmd(input logic [31:0] w);
    acc(1'b1, 12'h4FF, 1'b1, w, 1'b1);
  endtask

  task automatic status(input int cnt, input logic fl,
                        input logic lk, input logic er);
    idle();
    chk("count", ifc.count, cnt);
    chk("full", ifc.full, fl);
    chk("locked", ifc.locked, lk);
    chk("cmd_err", ifc.cmd_err, er);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    ifc.csr_enable   = 1'b0;
    ifc.csr_addr     = '0;
    ifc.csr_is_write = 1'b0;
    ifc.csr_wdata    = '0;
    sb.delete();
    model_va = '0;
    #2;
    chk("rst_count", ifc.count, 0);
    chk("rst_viol", ifc.violation, 0);
    chk("rst_va", ifc.violation_addr, 0);
    chk("rst_err", ifc.cmd_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_full", ifc.full, 0);
    chk("rst_locked", ifc.locked, 0);
    acc(1'b1, 12'h300, 1'b0, 32'h0, 1'b1);
    acc(1'b1, 12'h300, 1'b1, 32'h0, 1'b1);
    status(0, 1'b0, 1'b0, 1'b0);

    cmd(32'h0000_1300);
    acc(1'b1, 12'h300, 1'b1, 32'h0, 1'b0);
    acc(1'b1, 12'h300, 1'b1, 32'h0, 1'b0);
    acc(1'b1, 12'h300, 1'b0, 32'h0, 1'b1);
    status(1, 1'b0, 1'b0, 1'b0);

    cmd(32'hFFFF_1305);
    cmd(32'h0000_2305);
    status(2, 1'b0, 1'b0, 1'b0);
    acc(1'b1, 12'h305, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 6; i++) cmd(32'h1310 + i);
    status(8, 1'b1, 1'b0, 1'b0);
    cmd(32'h0000_2310);
    status(8, 1'b1, 1'b0, 1'b0);
    acc(1'b1, 12'h310, 1'b0, 32'h0, 1'b0);
    cmd(32'h0000_1320);
    status(8, 1'b1, 1'b0, 1'b1);
    acc(1'b1, 12'h320, 1'b1, 32'h0, 1'b1);

    cmd(32'h0000_4310);
    status(7, 1'b0, 1'b0, 1'b1);
    acc(1'b1, 12'h310, 1'b0, 32'h0, 1'b1);
    cmd(32'h0000_4777);
    status(7, 1'b0, 1'b0, 1'b1);
    cmd(32'h0000_8000);
    status(0, 1'b0, 1'b0, 1'b1);
    acc(1'b1, 12'h300, 1'b1, 32'h0, 1'b1);

    do_reset();
    cmd(32'h0000_14FF);
    status(0, 1'b0, 1'b0, 1'b1);
    acc(1'b1, 12'h4FF, 1'b0, 32'h0, 1'b1);

    do_reset();
    cmd(32'h0000_0300);
    status(0, 1'b0, 1'b0, 1'b1);
    acc(1'b1, 12'h300, 1'b1, 32'h0, 1'b1);

    do_reset();
    cmd(32'h0000_1300);
    cmd(32'h0000_C000);
    status(1, 1'b0, 1'b1, 1'b0);
    acc(1'b1, 12'h4FF, 1'b1, 32'h0000_8000, 1'b0);
    status(1, 1'b0, 1'b1, 1'b0);
    acc(1'b1, 12'h300, 1'b1, 32'h0, 1'b0);
    acc(1'b1, 12'h4FF, 1'b0, 32'h0, 1'b1);

    #2 rst_n = 1'b0;
    #1;
    chk("mid_locked", ifc.locked, 0);
    chk("mid_count", ifc.count, 0);
    chk("mid_viol", ifc.violation, 0);
    chk("mid_va", ifc.violation_addr, 0);
    chk("mid_en", ifc.csr_enable_out, 1);
    sb.delete();
    model_va = '0;
    ifc.csr_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc(1'b1, 12'h300, 1'b1, 32'h0, 1'b1);
    status(0, 1'b0, 1'b0, 1'b0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
